// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: opcodes, the sequencer state enum and
// the wide-op classifier. The optional WAIT watchdog is enabled by ALU_TIMEOUT_EN.
package alu_seq_pkg;

  localparam int OP_W_PKG = 5;
  typedef logic [OP_W_PKG-1:0] op_t;

  localparam op_t OP_ADD = 5'd0;
  localparam op_t OP_SUB = 5'd1;
  localparam op_t OP_AND = 5'd2;
  localparam op_t OP_OR  = 5'd3;
  localparam op_t OP_SHR = 5'd4;
  localparam op_t OP_SHL = 5'd5;
  localparam op_t OP_MUL = 5'd6;
  localparam op_t OP_DIV = 5'd7;
  localparam op_t OP_XOR = 5'd8;
  localparam op_t OP_NOT = 5'd9;

  typedef enum logic [2:0] {
    IDLE,
    LOADY,
    EXEC,
    WAIT,
    WB_LO,
    WB_HI,
    DONE
  } state_t;

  // Wide ops produce a 64-bit Z that lands in RLO/RHI instead of Ra.
  function automatic logic is_wide(input op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_sel_decoder.sv
// 4-to-NUM_REGS one-hot register select decoder with enable; all-zero when disabled.
module reg_sel_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic                en,
  input  logic [3:0]          idx,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = en && (idx == 4'(i));
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer moving Rb->RY, Rc->ALU B, Z->RZ and writing back to Ra or RLO/RHI.
// Define ALU_TIMEOUT_EN to add a watchdog on the WAIT state that raises sticky err.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
`ifdef ALU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [3:0]          cmd_ra,
  input  logic [3:0]          cmd_rb,
  input  logic [3:0]          cmd_rc,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                ry_in,
  output logic                rz_in,
  output logic                rz_lo_out,
  output logic                rz_hi_out,
  output logic                rlo_in,
  output logic                rhi_in,
  output logic [OP_W-1:0]     alu_op,
  output logic                alu_start,
  input  logic                alu_finished,
  output logic                done,
  output logic                err,
  output logic [2:0]          state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so a held cmd_valid is simply ignored while busy.

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [3:0]      ra_q, rb_q, rc_q;
  logic            out_en, in_en;
  logic [3:0]      out_idx;
  logic            timeout;
  logic            accept;

  assign accept    = cmd_valid && cmd_ready;
  assign alu_op    = (state_q == IDLE) ? '0 : op_q;
  assign state_dbg = state_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= cmd_op;
        ra_q <= cmd_ra;
        rb_q <= cmd_rb;
        rc_q <= cmd_rc;
      end
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // Count reaches TIMEOUT_CYCLES at the end of the TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == LOADY) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout && !alu_finished) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    out_en    = 1'b0;
    out_idx   = rb_q;
    in_en     = 1'b0;
    ry_in     = 1'b0;
    rz_in     = 1'b0;
    rz_lo_out = 1'b0;
    rz_hi_out = 1'b0;
    rlo_in    = 1'b0;
    rhi_in    = 1'b0;
    alu_start = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = LOADY;
      end
      LOADY: begin
        out_en  = 1'b1;
        ry_in   = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        out_en    = 1'b1;
        out_idx   = rc_q;
        alu_start = 1'b1;
        if (alu_finished) begin
          rz_in   = 1'b1;
          state_d = WB_LO;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Rc stays on the bus: the ALU B operand is taken live from it.
        out_en  = 1'b1;
        out_idx = rc_q;
        if (alu_finished) begin
          rz_in   = 1'b1;
          state_d = WB_LO;
        end else if (timeout) begin
          state_d = DONE;
        end
      end
      WB_LO: begin
        rz_lo_out = 1'b1;
        if (is_wide(op_t'(op_q))) begin
          rlo_in  = 1'b1;
          state_d = WB_HI;
        end else begin
          in_en   = 1'b1;
          state_d = DONE;
        end
      end
      WB_HI: begin
        rz_hi_out = 1'b1;
        rhi_in    = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_out_dec (
    .en  (out_en),
    .idx (out_idx),
    .sel (reg_out)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_in_dec (
    .en  (in_en),
    .idx (ra_q),
    .sel (reg_in)
  );

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control sequencer for the register-file/bus/ALU datapath.
- Accepts one register-to-register ALU command at a time, for example ADD Ra, Rb, Rc.
- Generates the one-hot bus-drive and register-load strobes that move Rb into RY, present Rc on the bus, start the ALU and capture Z into RZ.
- Writes the result back to Ra, or to RLO/RHI for wide ops.

Parameters:
- NUM_REGS, 16: general registers R0..R15; one-hot strobe width.
- OP_W, 5: ALU opcode width.
- TIMEOUT_CYCLES, 64: watchdog limit in the WAIT state. Used only with ALU_TIMEOUT_EN.

Ports:
- clock  in  1  : sole clock, rising edge.
- clear  in  1  : synchronous, active-high reset.
- cmd_valid  in  1  : command request.
- cmd_ready  out  1  : high only in IDLE.
- cmd_op  in  OP_W  : ALU opcode.
- cmd_ra  in  4  : destination register index.
- cmd_rb  in  4  : source A register index.
- cmd_rc  in  4  : source B register index.
- reg_out  out  NUM_REGS  : one-hot Rn-out bus select.
- reg_in  out  NUM_REGS  : one-hot Rn-in load enable.
- ry_in  out  1  : load RY.
- rz_in  out  1  : load RZ.
- rz_lo_out  out  1  : drive Z[31:0] onto the bus.
- rz_hi_out  out  1  : drive Z[63:32] onto the bus.
- rlo_in  out  1  : load RLO.
- rhi_in  out  1  : load RHI.
- alu_op  out  OP_W  : opcode to the ALU.
- alu_start  out  1  : one-cycle ALU start pulse.
- alu_finished  in  1  : ALU result valid.
- done  out  1  : one-cycle completion pulse.
- err  out  1  : timeout flag.

Behaviour:
- Reset: clock is the only clock; clear is synchronous active-high. On any edge with clear=1:
  - state -> IDLE.
  - All strobes, done and err go to 0; alu_op goes to 0.
  - The latched command is discarded; no done is issued.
  - This applies mid-operation too.
- Handshake: a command is accepted on an edge where cmd_valid & cmd_ready. The op and indices are latched on that edge. alu_op is driven from the latched op from then until the return to IDLE.
- State machine, one state per cycle except WAIT:
  - IDLE: cmd_ready=1, all strobes 0. On accept -> LOADY.
  - LOADY: reg_out[rb]=1, ry_in=1. -> EXEC.
  - EXEC: reg_out[rc]=1, alu_start=1.
    - If alu_finished=1 this cycle: rz_in=1, -> WB_LO.
    - Otherwise -> WAIT.
  - WAIT: reg_out[rc] stays high, because the ALU B operand is the live bus. On alu_finished: rz_in=1 the same cycle, -> WB_LO.
  - WB_LO: rz_lo_out=1.
    - Wide op: rlo_in=1, -> WB_HI.
    - Otherwise: reg_in[ra]=1, -> DONE.
  - WB_HI: rz_hi_out=1, rhi_in=1. -> DONE.
  - DONE: done=1. -> IDLE.
- Latency, accept edge to done high:
  - Single-cycle ALU, narrow op: 4 cycles.
  - Single-cycle ALU, wide op: 5 cycles.
  - Each extra cycle the ALU takes adds 1.
- Invariants:
  - At most one bus driver per cycle (reg_out, rz_lo_out, rz_hi_out).
  - At most one register load per cycle.
  - alu_start is high for exactly one cycle per command.
- Boundaries:
  - cmd_valid while busy is ignored; cmd_ready stays 0.
  - alu_finished outside EXEC/WAIT is ignored.
  - ra==rb, ra==rc and rb==rc are all legal, since transfers are sequential.
  - R0 is an ordinary register.
  - Wide ops write neither Ra nor any Rn.
- err: cleared on the next accepted command, not by DONE.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to EXEC and increments each cycle in WAIT.
  - When the count reaches TIMEOUT_CYCLES without alu_finished: err=1 (sticky), no rz_in, no writeback, -> DONE, so done still pulses.
  - alu_finished arriving on the same cycle as the timeout wins: normal completion, err stays 0.
- Without the macro: WAIT lasts indefinitely, err is tied to 0, and no counter is synthesized.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_MUL, OP_DIV, ...);
  - the state enum (IDLE, LOADY, EXEC, WAIT, WB_LO, WB_HI, DONE);
  - function is_wide(op), true for OP_MUL and OP_DIV.
- One sub-module, reg_sel_decoder: a 4-to-NUM_REGS one-hot decoder with an enable input. It is instantiated twice, once for reg_out and once for reg_in.

Test Plan:
1. ADD, ra=3, rb=1, rc=2, ALU finishes in EXEC. Required:
   - LOADY: reg_out=0x0002, ry_in=1.
   - EXEC: reg_out=0x0004, alu_start=1, rz_in=1.
   - WB_LO: rz_lo_out=1, reg_in=0x0008.
   - done high 4 cycles after accept; cmd_ready back high the cycle after done.
2. MUL, rb=5, rc=6, alu_finished 7 cycles after start. Required:
   - reg_out=0x0040 held through WAIT.
   - rz_in coincident with finished.
   - WB_LO: rlo_in=1; WB_HI: rhi_in=1.
   - reg_in stays 0 throughout.
3. cmd_valid held high through a whole command. Required:
   - Second command accepted only on the edge after done.
   - No strobe overlap.
4. clear asserted in WAIT. Required:
   - Next cycle all outputs 0, cmd_ready=1, no done.
   - A fresh command completes normally.
5. With ALU_TIMEOUT_EN, TIMEOUT_CYCLES=8, alu_finished never asserted. Required:
   - err=1 and done pulse 8 cycles after entering WAIT.
   - No reg_in or rlo_in.
   - err clears on the next accept.
6. ra=rb=rc=7, SUB. Required:
   - Strobes in order: reg_out=0x0080 (LOADY), reg_out=0x0080 (EXEC), reg_in=0x0080 (WB_LO).
   - Exactly one alu_start.
